// File: rtl/adder_pkg.sv
// Shared types and defaults for the chunked serial adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_NUM_BITS   = 16;
  localparam int DEF_CHUNK_BITS = 4;

  // Elaboration-time legality check for the width/chunk pairing.
  function automatic bit chunking_ok(input int num_bits, input int chunk_bits);
    return (chunk_bits > 0) && (num_bits >= chunk_bits) && ((num_bits % chunk_bits) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit adder slice; exports carry-out and the carry into its MSB.
module adder_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         carry_in,
  output logic [W-1:0] sum,
  output logic         overflow,
  output logic         carry_msb
);

  logic [W:0] w_full;

  assign w_full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};
  assign sum       = w_full[W-1:0];
  assign overflow  = w_full[W];
  // Carry into the MSB falls out of the MSB sum bit: s = a ^ b ^ cin.
  assign carry_msb = a[W-1] ^ b[W-1] ^ w_full[W-1];

endmodule

// File: rtl/serial_adder_nbit.sv
// Multi-cycle adder: CHUNK_BITS per clock with a start/busy/done handshake.
module serial_adder_nbit
  import adder_pkg::*;
#(
  parameter int NUM_BITS   = DEF_NUM_BITS,
  parameter int CHUNK_BITS = DEF_CHUNK_BITS
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  input  logic                signed_mode,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] sum,
  output logic                overflow
);

  localparam int NUM_CHUNKS = NUM_BITS / CHUNK_BITS;
  localparam int CNT_BITS   = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(NUM_CHUNKS - 1);

  if (!chunking_ok(NUM_BITS, CHUNK_BITS)) begin : g_bad_chunking
    $error("serial_adder_nbit: NUM_BITS must be a multiple of CHUNK_BITS");
  end

  typedef logic [NUM_CHUNKS-1:0][CHUNK_BITS-1:0] chunks_t;

  state_t              r_state;
  logic [CNT_BITS-1:0] r_cnt;
  chunks_t             r_a, r_b, r_work;
  logic                r_carry, r_signed;
  logic [NUM_BITS-1:0] r_sum;
  logic                r_ovf, r_busy, r_done;

  logic [CHUNK_BITS-1:0] w_csum;
  logic                  w_cout, w_cmsb, w_ovf;
  chunks_t               w_result;

  adder_chunk #(.W(CHUNK_BITS)) u_chunk (
    .a         (r_a[r_cnt]),
    .b         (r_b[r_cnt]),
    .carry_in  (r_carry),
    .sum       (w_csum),
    .overflow  (w_cout),
    .carry_msb (w_cmsb)
  );

  // Final chunk lands straight in the output register alongside earlier chunks.
  always_comb begin
    w_result        = r_work;
    w_result[r_cnt] = w_csum;
    w_ovf           = r_signed ? (w_cmsb ^ w_cout) : w_cout;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_work   <= '0;
      r_carry  <= 1'b0;
      r_signed <= 1'b0;
      r_sum    <= '0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_carry  <= carry_in;
            r_signed <= signed_mode;
            r_cnt    <= '0;
            r_work   <= '0;
            r_busy   <= 1'b1;
            r_state  <= ADD;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        ADD: begin
          if (32'(r_cnt) >= NUM_CHUNKS) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_work[r_cnt] <= w_csum;
            r_carry       <= w_cout;
            if (r_cnt == LAST) begin
              r_sum   <= w_result;
              r_ovf   <= w_ovf;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign overflow = r_ovf;

endmodule
